// File: rtl/mdu_sched_pkg.sv
//==============================================================================
// Module      : mdu_sched_pkg
// Description : Shared encodings for the multiply/divide scheduler: the MDU_*
//               op select values, the latched operation kind and FSM states.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mdu_sched_pkg;

    // Operation select driven on `op` by the E stage
    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MFHI  = 3'd4;
    localparam logic [2:0] MDU_MFLO  = 3'd5;
    localparam logic [2:0] MDU_MTHI  = 3'd6;
    localparam logic [2:0] MDU_MTLO  = 3'd7;

    // Kind of the long-latency operation held while RUN
    typedef enum logic [1:0] {
        KIND_MULT  = 2'd0,
        KIND_MULTU = 2'd1,
        KIND_DIV   = 2'd2,
        KIND_DIVU  = 2'd3
    } mdu_kind_e;

    // Scheduler state
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // MULT/MULTU/DIV/DIVU occupy the lower half of the op encoding
    function automatic logic op_is_muldiv(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic mdu_kind_e op_to_kind(input logic [2:0] op);
        mdu_kind_e k;
        case (op)
            MDU_MULTU: k = KIND_MULTU;
            MDU_DIV:   k = KIND_DIV;
            MDU_DIVU:  k = KIND_DIVU;
            default:   k = KIND_MULT;
        endcase
        return k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
//==============================================================================
// Module      : mdu_arith
// Description : Combinational multiply/divide datapath working on the latched
//               operands. Produces {hi,lo} and flags a zero divisor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mdu_arith
    import mdu_sched_pkg::*;
(
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  mdu_kind_e   kind,
    output logic [63:0] result,
    output logic        div_zero
);

    logic        w_is_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;

    // Single 64-bit multiplier shared by MULT/MULTU (sign- vs zero-extension),
    // and a magnitude divider with sign fix-up so truncation is toward zero.
    always_comb begin
        w_is_div  = (kind == KIND_DIV) || (kind == KIND_DIVU);
        div_zero  = w_is_div && (opb == 32'd0);

        w_ext_a   = (kind == KIND_MULT) ? {{32{opa[31]}}, opa} : {32'd0, opa};
        w_ext_b   = (kind == KIND_MULT) ? {{32{opb[31]}}, opb} : {32'd0, opb};
        w_prod    = w_ext_a * w_ext_b;

        w_a_neg   = (kind == KIND_DIV) && opa[31];
        w_b_neg   = (kind == KIND_DIV) && opb[31];
        w_mag_a   = w_a_neg ? (32'd0 - opa) : opa;
        w_mag_b   = w_b_neg ? (32'd0 - opb) : opb;
        // Keep the divider well defined on a zero divisor; the result is discarded
        w_divisor = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
        w_q_mag   = w_mag_a / w_divisor;
        w_r_mag   = w_mag_a % w_divisor;
        w_quot    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
        // Remainder follows the sign of the dividend
        w_rem     = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

        result    = w_is_div ? {w_rem, w_quot} : w_prod;
    end

endmodule

`default_nettype wire

// File: rtl/mdu_sched.sv
//==============================================================================
// Module      : mdu_sched
// Description : Multi-cycle multiply/divide scheduler for the E stage. Latches
//               operands, counts the fixed latency, commits into HI/LO and
//               drives busy for the stall controller.
//               Optional feature macro: MDU_FLUSH_EN (adds the flush port).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mdu_sched
    import mdu_sched_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    mdu_kind_e        kind_q,  kind_d;
    logic [31:0]      opa_q,   opa_d;
    logic [31:0]      opb_q,   opb_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;

    logic [63:0]      arith_result;
    logic             arith_div_zero;

    mdu_arith u_arith (
        .opa      (opa_q),
        .opb      (opb_q),
        .kind     (kind_q),
        .result   (arith_result),
        .div_zero (arith_div_zero)
    );

    // Next-state: accept work in IDLE, count down in RUN, commit on the last cycle
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        kind_d  = kind_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op_is_muldiv(op)) begin
                        opa_d   = a;
                        opb_d   = b;
                        kind_d  = op_to_kind(op);
                        count_d = ((op == MDU_DIV) || (op == MDU_DIVU))
                                  ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                        state_d = ST_RUN;
                    end else if (op == MDU_MTHI) begin
                        hi_d = a;
                    end else if (op == MDU_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_RUN: begin
                // start is ignored here; the stall controller never issues it
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (!arith_div_zero) begin
                        hi_d = arith_result[63:32];
                        lo_d = arith_result[31:0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

`ifdef MDU_FLUSH_EN
        // Flush cancels in-flight work and drops any same-cycle start, MTHI/MTLO included
        if (flush) begin
            state_d = ST_IDLE;
            count_d = '0;
            kind_d  = kind_q;
            opa_d   = opa_q;
            opb_d   = opb_q;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
`endif
    end

    // State, operand and HI/LO registers; reset dominates everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            kind_q  <= KIND_MULT;
            opa_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            kind_q  <= kind_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Outputs; rdata is a zero-latency HI/LO select
    always_comb begin
        busy  = (state_q == ST_RUN);
        hi    = hi_q;
        lo    = lo_q;
        rdata = (op == MDU_MFHI) ? hi_q : lo_q;
    end

endmodule

`default_nettype wire

// File: doc/mdu_sched.md
# mdu_sched

Multi-cycle multiply/divide scheduler for the E stage of the five-stage pipeline. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operation per cycle from E, latches the operands, and counts the fixed multiply or divide latency. It commits results into its HI/LO registers and drives `busy` so that `StallCtrl` can hold an HI/LO-class instruction in D while an operation is in flight.

## Interface

Parameters:
- `MUL_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `start` input 1: valid operation in E this cycle; already squashed by the E-stage clear.
- `op` input 3: operation select, encoded by the `MDU_*` constants.
- `a` input 32: rs value, forwarded (`V1$E$FWD`).
- `b` input 32: rt value, forwarded (`V2$E$FWD`).
- `flush` input 1: cancel any in-flight operation; present only with `MDU_FLUSH_EN`.
- `busy` output 1: an operation is in flight; reset value 0.
- `hi` output 32: committed HI; reset value 0.
- `lo` output 32: committed LO; reset value 0.
- `rdata` output 32: `hi` when `op`==MFHI, else `lo`; combinational; reset value 0 (`lo`).

## Operation

- States:
  - IDLE: `count`==0 and `busy`=0.
  - RUN: `count`!=0 and `busy`=1.
  - A latched `kind` register (MUL/DIV, signed/unsigned) is held alongside the state.
- IDLE, `start` with MULT/MULTU/DIV/DIVU:
  - Latch `a` and `b` into operand registers and latch `kind`.
  - Load `count` with MUL_CYCLES or DIV_CYCLES.
  - Go to RUN.
- IDLE, `start` with MTHI/MTLO: write `a` into HI/LO at the edge and stay in IDLE.
- MFHI/MFLO have no state effect; they only select `rdata`.
- RUN: decrement `count` on every edge. On the edge where `count` goes 1→0, commit the result to HI/LO and return to IDLE.
- `start` while in RUN is ignored, whatever the op. `StallCtrl` guarantees this does not occur; the verifier asserts it never happens.
- Arithmetic, computed from the latched operands only:
  - MULT: signed 32×32→64; HI = bits [63:32], LO = bits [31:0].
  - MULTU: the same, unsigned.
  - DIV: signed division truncating toward zero; LO = quotient, HI = remainder, remainder takes the sign of the dividend.
  - DIVU: unsigned division.
  - Divisor 0: the operation still runs DIV_CYCLES with `busy` high, but the commit is suppressed and HI/LO are unchanged.
- Changes to `a`/`b` after the start edge have no effect on the result.
- `reset` wins over `start`, `flush` and commit in the same cycle.
- `reset` during RUN aborts the operation: `count`=0, HI=LO=0.

## Timing

- Multiply or divide started by `start` sampled at edge 0:
  - `busy` is high in cycles 1..N, where N = MUL_CYCLES or DIV_CYCLES.
  - The new `hi`/`lo` values are visible in cycle N+1, with `busy` low in the same cycle.
- Back-to-back: a second operation may start in cycle N+1 and sees the committed HI/LO.
- MTHI/MTLO sampled at edge 0: the new value is visible in cycle 1; `busy` stays 0.
- `rdata` has zero latency from `op`, `hi` and `lo`.
- Stall rule for `StallCtrl`: stall D when the D instruction is HI/LO-class and either (`start` && `op` is mult/div) or `busy`.

## Configuration

- `MDU_FLUSH_EN` defined:
  - The `flush` port exists.
  - `flush` high at an edge forces `count`=0 and suppresses that cycle's commit; HI/LO keep their pre-operation values.
  - `flush` and `start` in the same cycle: the flush wins and `start` is dropped. This includes MTHI/MTLO.
  - The port is reserved for exception handling.
- `MDU_FLUSH_EN` undefined: there is no `flush` port and no flush logic; in-flight operations always complete.

## Structure

- The `MDU_*` op encodings are added to `Constants.v`:
  - MULT=0, MULTU=1, DIV=2, DIVU=3, MFHI=4, MFLO=5, MTHI=6, MTLO=7.
  - The same file holds the `kind` encoding.
- One sub-module, `mdu_arith`:
  - Purely combinational.
  - Takes the latched operands and `kind`.
  - Outputs the 64-bit {hi,lo} result and a `div_zero` flag.
- `mdu_sched` holds the counter, state, operand, HI and LO registers.

## Test plan

- Reset, then idle: `busy`=0, `hi`=`lo`=0, `rdata`=0.
- MULT with a=0xFFFFFFFD (−3), b=5: `busy` high for cycles 1–5; in cycle 6, `hi`=0xFFFFFFFF and `lo`=0xFFFFFFF1.
- MULTU with a=0xFFFFFFFF, b=2: `hi`=0x00000001, `lo`=0xFFFFFFFE. Change `a` during busy: the result is unchanged.
- DIV with a=0xFFFFFFF9 (−7), b=2: `busy` high for cycles 1–10; in cycle 11, `lo`=0xFFFFFFFD and `hi`=0xFFFFFFFF.
- MTHI 0x1234 then DIVU 7/0:
  - `hi` reads 0x1234 in cycle 1.
  - `busy` is high for 10 cycles.
  - Afterwards `hi`=0x1234 and `lo`=0.
- Interrupted MULT, from `hi`=`lo`=0:
  - Start MULT 3×4 and assert `reset` at cycle 3: in cycle 4, `busy`=0 and `hi`=`lo`=0.
  - With `MDU_FLUSH_EN`, assert `flush` at cycle 3 instead: `busy` drops in cycle 4, and `lo` stays 0 (not 12).
